// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared widths, entry layout and state enum for the FIFO write arbiter
package fifo_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int SRC_W   = 2;
  localparam int SEQ_W   = 2;
  localparam int N_REQ   = 2 ** SRC_W;
  localparam int ENTRY_W = SRC_W + SEQ_W + DATA_W;

  // Entry field offsets: {src, seq, data}
  localparam int DATA_LSB = 0;
  localparam int SEQ_LSB  = DATA_W;
  localparam int SRC_LSB  = DATA_W + SEQ_W;

  // Hold-stage condition, derived from hold_valid and fifo_full
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADED  = 2'd1,
    STALLED = 2'd2
  } hold_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [SRC_W-1:0]  src,
                                                    input logic [SEQ_W-1:0]  seq,
                                                    input logic [DATA_W-1:0] data);
    return {src, seq, data};
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational 4-way round-robin picker
module rr_pick
  import fifo_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0] id_o,
  output logic             valid_o
);

  logic [SRC_W-1:0] idx;

  // Scan from last+1 upward with natural modulo wrap; first set request wins,
  // and the previous winner is visited last.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last_i + SRC_W'(i);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        id_o       = idx;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin write arbiter for a shared FIFO port; FIFO_ARB_PRIORITY_EN gives requester 0 strict priority
module fifo_write_arbiter
  import fifo_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_err,
  output logic                    fifo_write,
  output logic [ENTRY_W-1:0]      fifo_in,
  output logic [SRC_W-1:0]        grant_src,
  output logic                    err_sticky,
  input  logic                    err_clr,
  output logic [7:0]              stall_cnt
);

  logic                hold_valid_q, hold_valid_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [SEQ_W-1:0]    seq_q [N_REQ];
  logic [SEQ_W-1:0]    seq_d [N_REQ];
  logic [SRC_W-1:0]    last_grant_q, last_grant_d;
  logic [SRC_W-1:0]    grant_src_q, grant_src_d;
  logic                err_sticky_q, err_sticky_d;
  logic [7:0]          stall_cnt_q, stall_cnt_d;

  logic                load;
  hold_state_e         state;

  logic [N_REQ-1:0]    pick_req, pick_gnt;
  logic [SRC_W-1:0]    pick_id;
  logic                pick_any;

  logic [N_REQ-1:0]    win_gnt;
  logic [SRC_W-1:0]    win_id;
  logic                win_any;
  logic                win_moves_ptr;
  logic [DATA_W-1:0]   win_data;

  assign fifo_write = hold_valid_q & ~fifo_full;
  assign load       = ~hold_valid_q | fifo_write;

  assign fifo_in    = entry_q;
  assign grant_src  = grant_src_q;
  assign err_sticky = err_sticky_q;
  assign stall_cnt  = stall_cnt_q;

`ifdef FIFO_ARB_PRIORITY_EN
  // Keypad is removed from the rotation; the pointer only tracks requesters 1-3.
  assign pick_req = {req_valid[N_REQ-1:1], 1'b0};
`else
  assign pick_req = req_valid;
`endif

  rr_pick u_rr_pick (
    .req_i   (pick_req),
    .last_i  (last_grant_q),
    .gnt_o   (pick_gnt),
    .id_o    (pick_id),
    .valid_o (pick_any)
  );

  // Select the winner; under priority mode requester 0 pre-empts the rotation.
  always_comb begin
    win_gnt       = pick_gnt;
    win_id        = pick_id;
    win_any       = pick_any;
    win_moves_ptr = pick_any;
`ifdef FIFO_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      win_gnt       = {{(N_REQ-1){1'b0}}, 1'b1};
      win_id        = '0;
      win_any       = 1'b1;
      win_moves_ptr = 1'b0;
    end
`endif
  end

  assign win_data = req_data[win_id*DATA_W +: DATA_W];

  // Hold-stage condition, used to qualify the stall counter.
  always_comb begin
    state = EMPTY;
    if (hold_valid_q) state = fifo_full ? STALLED : LOADED;
  end

  // Accept path: when the stage can take a new entry, grant one requester and pack its entry.
  always_comb begin
    hold_valid_d = hold_valid_q;
    entry_d      = entry_q;
    seq_d        = seq_q;
    last_grant_d = last_grant_q;
    grant_src_d  = grant_src_q;
    req_ready    = '0;
    if (load) begin
      if (win_any) begin
        req_ready       = win_gnt;
        hold_valid_d    = 1'b1;
        entry_d         = pack_entry(win_id, seq_q[win_id], win_data);
        seq_d[win_id]   = seq_q[win_id] + 1'b1;
        grant_src_d     = win_id;
        if (win_moves_ptr) last_grant_d = win_id;
      end else begin
        hold_valid_d = 1'b0;
      end
    end
  end

  // Debug status: sticky error (set dominates clear) and saturating stall count.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (fifo_err)     err_sticky_d = 1'b1;
    else if (err_clr) err_sticky_d = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (err_clr)                                       stall_cnt_d = '0;
    else if (state == STALLED && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
  end

  // State registers; reset discards any held entry and makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      entry_q      <= '0;
      for (int i = 0; i < N_REQ; i++) seq_q[i] <= '0;
      last_grant_q <= SRC_W'(N_REQ - 1);
      grant_src_q  <= '0;
      err_sticky_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      entry_q      <= entry_d;
      seq_q        <= seq_d;
      last_grant_q <= last_grant_d;
      grant_src_q  <= grant_src_d;
      err_sticky_q <= err_sticky_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_err;
  logic        fifo_write;
  logic [19:0] fifo_in;
  logic [1:0]  grant_src;
  logic        err_sticky;
  logic        err_clr;
  logic [7:0]  stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  fifo_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_err   (fifo_err),
    .fifo_write (fifo_write),
    .fifo_in    (fifo_in),
    .grant_src  (grant_src),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; checks run 1 ns later, well away from the rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_err = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b0001; req_data = 64'h1111; fifo_full = 1'b0;
    fifo_err = 1'b0; err_clr = 1'b0;
    #1;
    n_vec++;
    if (fifo_write !== 1'b0 || fifo_in !== 20'h0 || grant_src !== 2'd0 ||
        err_sticky !== 1'b0 || stall_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_regs: write=%b in=%h gs=%0d err=%b stall=%0d, want 0 0 0 0 0",
               fifo_write, fifo_in, grant_src, err_sticky, stall_cnt);
    end
    req_valid = '0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_data = {48'h0, 16'h1234};
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_vec++;
    if (fifo_write !== 1'b1 || fifo_in !== 20'h01234 || grant_src !== 2'd0) begin
      n_bad++;
      $display("FAIL single_entry: write=%b in=%h gs=%0d want 1 01234 0", fifo_write, fifo_in, grant_src);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (fifo_write !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain: fifo_write=%b want 0", fifo_write);
    end
  endtask

  task automatic test_round_robin();
    logic [19:0] exp_entry;
    logic [3:0]  exp_ready;
    do_reset();
    req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) begin
        exp_ready = 4'b0001 << (k % 4);
        n_vec++;
        if (req_ready !== exp_ready) begin
          n_bad++;
          $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
        end
      end
      if (k > 0) begin
        exp_entry = {2'((k-1) % 4), 2'((k-1) / 4), 16'hA000 + 16'((k-1) % 4)};
        n_vec++;
        if (fifo_write !== 1'b1 || fifo_in !== exp_entry) begin
          n_bad++;
          $display("FAIL rr_entry[%0d]: write=%b in=%h want 1 %h", k-1, fifo_write, fifo_in, exp_entry);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_seq_wrap();
    logic [19:0] exp_entry;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 5) ? 4'b0100 : 4'b0000;
      req_data  = {16'h0, 16'h00C0 + 16'(k), 32'h0};
      #1;
      if (k > 0) begin
        exp_entry = {2'd2, 2'((k-1) % 4), 16'h00C0 + 16'(k-1)};
        n_vec++;
        if (fifo_in !== exp_entry || grant_src !== 2'd2) begin
          n_bad++;
          $display("FAIL seq_wrap[%0d]: in=%h gs=%0d want %h 2", k-1, fifo_in, grant_src, exp_entry);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b0010; req_data = {16'h0, 16'h0, 16'hBEEF, 16'h5A5A};
    @(negedge clk);
    req_valid = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      fifo_full = 1'b1;
      #1;
      n_vec++;
      if (fifo_write !== 1'b0 || req_ready !== 4'b0000 || fifo_in !== 20'h4BEEF) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: write=%b ready=%b in=%h want 0 0000 4beef",
                 k, fifo_write, req_ready, fifo_in);
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
    #1;
    n_vec++;
    if (stall_cnt !== 8'd10 || fifo_write !== 1'b1 || fifo_in !== 20'h4BEEF || req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL stall_release: cnt=%0d write=%b in=%h ready=%b want 10 1 4beef 0001",
               stall_cnt, fifo_write, fifo_in, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_vec++;
    if (fifo_write !== 1'b1 || fifo_in !== 20'h05A5A || stall_cnt !== 8'd10) begin
      n_bad++;
      $display("FAIL stall_next: write=%b in=%h cnt=%0d want 1 05a5a 10", fifo_write, fifo_in, stall_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_err();
    fifo_err = 1'b1;
    @(negedge clk);
    fifo_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (err_sticky !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: got %b want 1", err_sticky);
    end
    fifo_err = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    fifo_err = 1'b0; err_clr = 1'b0;
    #1;
    n_vec++;
    if (err_sticky !== 1'b1 || stall_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL err_clr_collide: err=%b cnt=%0d want 1 0", err_sticky, stall_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    n_vec++;
    if (err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr: got %b want 0", err_sticky);
    end
  endtask

  task automatic test_stall_saturate();
    do_reset();
    req_valid = 4'b1000; req_data = {16'h7777, 48'h0};
    @(negedge clk);
    req_valid = 4'b0000; fifo_full = 1'b1;
    repeat (260) @(negedge clk);
    #1;
    n_vec++;
    if (stall_cnt !== 8'd255 || fifo_write !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_sat: cnt=%0d write=%b want 255 0", stall_cnt, fifo_write);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (fifo_write !== 1'b0 || fifo_in !== 20'h0 || stall_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_stall: write=%b in=%h cnt=%0d want 0 0 0", fifo_write, fifo_in, stall_cnt);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (fifo_write !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: fifo_write=%b want 0", fifo_write);
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_ready;
    do_reset();
    req_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4) ? 4'b1111 : 4'b1110;
      exp_ready = (k < 4) ? 4'b0001 : (4'b0001 << (k - 3));
      #1;
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_bad++;
        $display("FAIL prio_ready[%0d]: got %b want %b", k, req_ready, exp_ready);
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_err = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
`ifdef FIFO_ARB_PRIORITY_EN
    test_priority();
`else
    test_round_robin();
`endif
    test_seq_wrap();
    test_stall();
    test_err();
    test_stall_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
